oram_arb: RTL and testbench
===========================

ORAM_ARB -- requirements
Module: oram_arb

Interface
REQ-001 Parameter ADDR_W, default 13, RAM word address width.
REQ-002 Parameter DATA_W, default 64, RAM word width (16 x INT4).
REQ-003 Parameter WQ_DEPTH, default 4, write-queue entries (power of two, >=2).
REQ-004 i_clk  in  1  single clock; all logic on rising edge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_wr_valid / o_wr_ready  in/out  1/1  write-request handshake from PPU.
REQ-007 i_wr_addr / i_wr_data  in  ADDR_W / DATA_W  write address and word.
REQ-008 i_rd_valid / o_rd_ready  in/out  1/1  read-request handshake from readout requester.
REQ-009 i_rd_addr  in  ADDR_W  read address.
REQ-010 o_rd_dvalid / o_rd_data  out  1 / DATA_W  read response; no backpressure.
REQ-011 o_ram_we / o_ram_addr / o_ram_wdata  out  1 / ADDR_W / DATA_W  registered RAM command.
REQ-012 i_ram_rdata  in  DATA_W  RAM read data, valid one cycle after command.
REQ-013 o_wr_cnt  out  ADDR_W+1  count of writes committed to RAM since reset.
REQ-014 o_idle  out  1  queue empty and no read in flight.

Function
REQ-015 Write handshake completes when i_wr_valid && o_wr_ready; word pushed into FIFO-ordered write queue.
REQ-016 o_wr_ready = queue not full, from registered occupancy only (no combinational path from i_wr_valid).
REQ-017 Push and pop in same cycle allowed when queue non-empty; occupancy unchanged.
REQ-018 Each cycle arbiter grants at most one of: W (queue head, if non-empty) or R (read request, if eligible).
REQ-019 R eligible only if i_rd_valid and i_rd_addr matches no valid queue entry (read-after-write ordering); ineligible read waits, o_rd_ready low.
REQ-020 Both contend: queue full -> W wins; otherwise round-robin, loser of last contended cycle wins; pointer resets to favour W.
REQ-021 o_rd_ready = R granted this cycle (combinational from i_rd_valid, i_rd_addr, state).
REQ-022 Grant W at cycle T: o_ram_we=1, o_ram_addr/o_ram_wdata = head at T+1; head popped at T; o_wr_cnt increments at T+1.
REQ-023 Grant R at cycle T: o_ram_we=0, o_ram_addr=i_rd_addr at T+1; o_rd_dvalid=1, o_rd_data=registered i_ram_rdata at T+3.
REQ-024 Back-to-back reads accepted every cycle; up to 3 in flight via 3-stage valid shift register; responses in request order.
REQ-025 No grant: o_ram_we=0, o_ram_addr/o_ram_wdata hold previous value.
REQ-026 o_wr_cnt wraps modulo 2^(ADDR_W+1).
REQ-027 Write just pushed (cycle T) participates in hazard check from T+1; read at T to same address with empty queue is not blocked (ordering defined by handshake cycle).

Reset
REQ-028 i_rst high at edge: queue emptied, pointers 0, in-flight reads discarded, RR pointer to W.
REQ-029 Reset values: o_ram_we=0, o_ram_addr=0, o_ram_wdata=0, o_rd_dvalid=0, o_rd_data=0, o_wr_cnt=0; o_wr_ready=1 and o_idle=1 first cycle after reset.
REQ-030 Reset mid-operation: queued writes lost, no response for reads in flight.

Structure
REQ-031 Package oram_pkg holds ADDR_W/DATA_W defaults and grant-select enum {GNT_NONE, GNT_W, GNT_R}.
REQ-032 Write queue as sub-module oram_wq (sync FIFO, exposes all entries + valid bits for hazard compare).
REQ-033 Arbiter, command register, read-valid pipeline in oram_arb.

Verification
REQ-034 Single write addr 5 data 0xA5A5, no reads -> o_ram_we=1, addr 5 two cycles after handshake; o_wr_cnt=1.
REQ-035 5 writes back-to-back, no pops possible (read streaming to other addresses) -> o_wr_ready low after 4 pushes; W forced next cycle.
REQ-036 Write addr 9 queued, read addr 9 same following cycle -> o_rd_ready low until write issued; response data = written word.
REQ-037 Continuous write and read contention -> grants alternate W,R,W,R starting W after reset.
REQ-038 3 back-to-back reads addrs 1,2,3 preloaded 0x11,0x22,0x33 -> o_rd_dvalid 3 consecutive cycles, data in order.
REQ-039 i_rst asserted with 2 queued writes and 2 reads in flight -> next cycle o_ram_we=0, o_rd_dvalid=0 for 3 cycles, o_wr_cnt=0.

Source files
------------

// File: rtl/oram_pkg.sv
// rtl/oram_pkg.sv - shared widths and grant encoding for the output-RAM arbiter
package oram_pkg;

    localparam int ADDR_W_DEF   = 13;
    localparam int DATA_W_DEF   = 64;
    localparam int WQ_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_W    = 2'd1,
        GNT_R    = 2'd2
    } gnt_e;

endpackage

// File: rtl/oram_wq.sv
// rtl/oram_wq.sv - synchronous write-queue FIFO exposing every slot for hazard compare
module oram_wq #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [ADDR_W-1:0]            head_addr,
    output logic [DATA_W-1:0]            head_data,
    output logic [DEPTH-1:0][ADDR_W-1:0] ent_addr,
    output logic [DEPTH-1:0]             ent_valid,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                addr_mem[wr_ptr] <= push_addr;
                data_mem[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PTR_W+1)'(1);
            end
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_addr[i]  = addr_mem[i];
            ent_valid[i] = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < count);
        end
    end

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign empty     = (count == '0);

endmodule

// File: rtl/oram_arb.sv
// rtl/oram_arb.sv - output-RAM arbiter: queued writes vs. reads, registered RAM command
module oram_arb
    import oram_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WQ_DEPTH = WQ_DEPTH_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_valid,
    output logic              o_rd_ready,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_dvalid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic [ADDR_W:0]   o_wr_cnt,
    output logic              o_idle
);

    logic                           wq_full;
    logic                           wq_empty;
    logic [ADDR_W-1:0]              head_addr;
    logic [DATA_W-1:0]              head_data;
    logic [WQ_DEPTH-1:0][ADDR_W-1:0] ent_addr;
    logic [WQ_DEPTH-1:0]            ent_valid;
    logic                           push;
    logic                           pop;
    logic                           hazard;
    logic                           w_req;
    logic                           r_req;
    logic                           favour_r;
    logic [2:0]                     rd_vld;
    gnt_e                           gnt;

    oram_wq #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (WQ_DEPTH)
    ) u_wq (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (push),
        .push_addr (i_wr_addr),
        .push_data (i_wr_data),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .ent_addr  (ent_addr),
        .ent_valid (ent_valid),
        .full      (wq_full),
        .empty     (wq_empty)
    );

    assign o_wr_ready = !wq_full;
    assign push       = i_wr_valid && o_wr_ready;

    // A read may not overtake any queued write to the same word.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i] == i_rd_addr)) begin
                hazard = 1'b1;
            end
        end
    end

    assign w_req = !wq_empty;
    assign r_req = i_rd_valid && !hazard;

    always_comb begin
        gnt = GNT_NONE;
        if (w_req && r_req) begin
            gnt = (wq_full || !favour_r) ? GNT_W : GNT_R;
        end else if (w_req) begin
            gnt = GNT_W;
        end else if (r_req) begin
            gnt = GNT_R;
        end
    end

    assign pop        = (gnt == GNT_W);
    assign o_rd_ready = (gnt == GNT_R);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            favour_r    <= 1'b0;
            o_ram_we    <= 1'b0;
            o_ram_addr  <= '0;
            o_ram_wdata <= '0;
            o_wr_cnt    <= '0;
            rd_vld      <= '0;
            o_rd_data   <= '0;
        end else begin
            if (w_req && r_req) begin
                favour_r <= (gnt == GNT_W);
            end
            case (gnt)
                GNT_W: begin
                    o_ram_we    <= 1'b1;
                    o_ram_addr  <= head_addr;
                    o_ram_wdata <= head_data;
                    o_wr_cnt    <= o_wr_cnt + (ADDR_W+1)'(1);
                end
                GNT_R: begin
                    o_ram_we   <= 1'b0;
                    o_ram_addr <= i_rd_addr;
                end
                default: begin
                    o_ram_we <= 1'b0;
                end
            endcase
            // Stage 0: command on the bus, stage 1: RAM data arriving, stage 2: response out.
            rd_vld <= {rd_vld[1:0], (gnt == GNT_R)};
            if (rd_vld[1]) begin
                o_rd_data <= i_ram_rdata;
            end
        end
    end

    assign o_rd_dvalid = rd_vld[2];
    assign o_idle      = wq_empty && (rd_vld == 3'b000);

endmodule

// File: tb/tb_oram_arb.sv
// tb/tb_oram_arb.sv - directed and random checks of oram_arb against a transaction-level model
module tb_oram_arb;

    localparam int AW = 13;
    localparam int DW = 64;
    localparam int WQ = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_dvalid;
    logic [DW-1:0] rd_data;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [AW:0]   wr_cnt;
    logic          idle;

    logic          ram_clr;
    logic [DW-1:0] ram [16];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           mq[$];
    logic [DW-1:0] mmem [16];
    bit            m_fav_r;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [AW:0]   m_cnt;
    bit            m_pv [3];
    logic [DW-1:0] m_pd [3];
    bit            dut_rd_ready;

    int n_cmp = 0;
    int n_err = 0;

    oram_arb #(.ADDR_W(AW), .DATA_W(DW), .WQ_DEPTH(WQ)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wr_valid  (wr_valid),
        .o_wr_ready  (wr_ready),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_rd_valid  (rd_valid),
        .o_rd_ready  (rd_ready),
        .i_rd_addr   (rd_addr),
        .o_rd_dvalid (rd_dvalid),
        .o_rd_data   (rd_data),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata),
        .o_wr_cnt    (wr_cnt),
        .o_idle      (idle)
    );

    always #5 clk = ~clk;

    // RAM with one cycle of read latency, read-before-write.
    always @(posedge clk) begin
        if (ram_clr) begin
            foreach (ram[i]) ram[i] <= '0;
        end else begin
            ram_rdata <= ram[ram_addr[3:0]];
            if (ram_we) ram[ram_addr[3:0]] <= ram_wdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_fav_r = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_cnt   = '0;
        for (int i = 0; i < 3; i++) m_pv[i] = 1'b0;
        check("rst_ram_we",    64'(ram_we),    64'd0);
        check("rst_ram_addr",  64'(ram_addr),  64'd0);
        check("rst_ram_wdata", 64'(ram_wdata), 64'd0);
        check("rst_wr_cnt",    64'(wr_cnt),    64'd0);
        check("rst_rd_dvalid", 64'(rd_dvalid), 64'd0);
        check("rst_rd_data",   64'(rd_data),   64'd0);
        check("rst_wr_ready",  64'(wr_ready),  64'd1);
        check("rst_idle",      64'(idle),      64'd1);
    endtask

    // One clock: drive inputs, check handshake outputs, advance model, check registered outputs.
    task automatic cycle(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic rv, input logic [AW-1:0] ra);
        int  n;
        int  g;
        bit  full;
        bit  haz;
        bit  wreq;
        bit  rreq;
        wr_t h;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        rd_valid = rv;
        rd_addr  = ra;
        #1;
        n    = mq.size();
        full = (n == WQ);
        haz  = 1'b0;
        foreach (mq[i]) if (mq[i].addr == ra) haz = 1'b1;
        wreq = (n > 0);
        rreq = rv && !haz;
        if (wreq && rreq) begin
            g = (full || !m_fav_r) ? 1 : 2;
            m_fav_r = (g == 1);
        end else if (wreq) begin
            g = 1;
        end else if (rreq) begin
            g = 2;
        end else begin
            g = 0;
        end
        dut_rd_ready = rd_ready;
        check("wr_ready", 64'(wr_ready), 64'(!full));
        check("rd_ready", 64'(rd_ready), 64'(g == 2));
        check("idle",     64'(idle),     64'((n == 0) && !(m_pv[0] || m_pv[1] || m_pv[2])));
        @(posedge clk);
        m_pv[2] = m_pv[1];  m_pd[2] = m_pd[1];
        m_pv[1] = m_pv[0];  m_pd[1] = m_pd[0];
        m_pv[0] = (g == 2); m_pd[0] = mmem[ra[3:0]];
        if (g == 1) begin
            h       = mq.pop_front();
            m_we    = 1'b1;
            m_addr  = h.addr;
            m_wdata = h.data;
            m_cnt   = m_cnt + 1'b1;
            mmem[h.addr[3:0]] = h.data;
        end else if (g == 2) begin
            m_we   = 1'b0;
            m_addr = ra;
        end else begin
            m_we = 1'b0;
        end
        if (wv && !full) mq.push_back('{addr: wa, data: wd});
        #1;
        check("ram_we",    64'(ram_we),    64'(m_we));
        check("ram_addr",  64'(ram_addr),  64'(m_addr));
        check("ram_wdata", 64'(ram_wdata), 64'(m_wdata));
        check("wr_cnt",    64'(wr_cnt),    64'(m_cnt));
        check("rd_dvalid", 64'(rd_dvalid), 64'(m_pv[2]));
        if (m_pv[2]) check("rd_data", 64'(rd_data), 64'(m_pd[2]));
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) cycle(1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        int tries;
        rst      = 1'b1;
        ram_clr  = 1'b1;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr  = '0;
        foreach (mmem[i]) mmem[i] = '0;
        @(posedge clk);
        #1;
        ram_clr = 1'b0;
        do_reset();

        // Single write, no reads.
        cycle(1'b1, 13'd5, 64'hA5A5, 1'b0, '0);
        idle_cycles(2);
        check("single_wr_cnt", 64'(wr_cnt), 64'd1);

        // Preload 1,2,3 then three back-to-back reads.
        cycle(1'b1, 13'd1, 64'h11, 1'b0, '0);
        cycle(1'b1, 13'd2, 64'h22, 1'b0, '0);
        cycle(1'b1, 13'd3, 64'h33, 1'b0, '0);
        idle_cycles(3);
        cycle(1'b0, '0, '0, 1'b1, 13'd1);
        cycle(1'b0, '0, '0, 1'b1, 13'd2);
        cycle(1'b0, '0, '0, 1'b1, 13'd3);
        idle_cycles(4);

        // Read-after-write to address 9 must wait for the write to issue.
        cycle(1'b1, 13'd9, 64'h9999_0000_CAFE_0009, 1'b0, '0);
        tries = 0;
        dut_rd_ready = 1'b0;
        while (tries < 8 && !dut_rd_ready) begin
            cycle(1'b0, '0, '0, 1'b1, 13'd9);
            tries++;
        end
        check("raw_wait_cycles", 64'(tries), 64'd2);
        idle_cycles(4);

        // Sustained contention: alternation, queue filling, forced write.
        do_reset();
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 13'(4 + (i % 4)), {32'hC0DE, 32'(i)}, 1'b1, 13'(10 + (i % 4)));
        idle_cycles(6);

        // Reset with queued writes and reads in flight.
        cycle(1'b1, 13'd4, 64'h4444, 1'b1, 13'd10);
        cycle(1'b1, 13'd5, 64'h5555, 1'b1, 13'd11);
        cycle(1'b1, 13'd6, 64'h6666, 1'b1, 13'd12);
        do_reset();
        idle_cycles(3);

        // Random traffic over a small address window to exercise hazards.
        for (int i = 0; i < 500; i++) begin
            if (i == 250) do_reset();
            cycle(1'($urandom_range(0, 1)), 13'($urandom_range(0, 7)), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 13'($urandom_range(0, 7)));
        end
        idle_cycles(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
